// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the I2S transmit path
// Purpose: sample and stereo-pair types carried from the IIR filter to the
//          I2S serializer, plus frame geometry.
// Ports:   none (package).
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    localparam int FRAME_BITS = 32;
    localparam int BIT_W      = $clog2(FRAME_BITS);

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - first-word fall-through FIFO of stereo pairs
// Purpose: buffers left/right pairs between the filter strobe and the
//          I2S frame start. The caller guarantees push is only asserted
//          when not full (or together with pop) and pop only when not empty.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   push, din      write strobe and pair to store
//   pop, dout      read strobe and head pair (valid whenever !empty)
//   full, empty    occupancy status
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  logic    pop,
    input  stereo_t din,
    output stereo_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    stereo_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    // Head is read combinationally so a pop and a push into the same slot
    // (full FIFO) still returns the old head.
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - stereo I2S serializer with sample FIFO and sticky status
// Purpose: captures {input_l, input_r} on sample_ce into a FIFO and shifts
//          each pair out MSB-first in a 32-bit I2S frame with the standard
//          one-bit delay. Bit and word clocks are derived from clk.
// Build option: AUDIO_I2S_TX_ZERO_ON_UNDERRUN_EN - when defined, an underrun
//          frame sends silence instead of repeating the last pair.
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   sample_ce          one-cycle capture strobe for input_l / input_r
//   input_l, input_r   signed 16-bit left / right samples
//   clr_status         synchronous clear of underrun / overflow
//   i2s_bclk           bit clock (period 2*BCLK_DIV clk cycles)
//   i2s_lrck           word select, 0 = left, 1 = right
//   i2s_sdata          serial data, changes on bclk falling edge
//   underrun           sticky: a frame started with the FIFO empty
//   overflow           sticky: sample_ce arrived with the FIFO full
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_ce,
    input  logic signed [15:0] input_l,
    input  logic signed [15:0] input_r,
    input  logic               clr_status,
    output logic               i2s_bclk,
    output logic               i2s_lrck,
    output logic               i2s_sdata,
    output logic               underrun,
    output logic               overflow
);

    localparam int DIV_W = $clog2(BCLK_DIV);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             r_lrck;
    logic             r_sdata;
    logic             r_underrun;
    logic             r_overflow;
    logic [BIT_W-1:0] r_bit_idx;
    stereo_t          r_frame_word;

    logic             w_div_wrap;
    logic             w_fall;
    logic             w_frame_start;
    logic [BIT_W-1:0] w_bit_next;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    stereo_t          w_din;
    stereo_t          w_head;

    assign w_div_wrap    = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    assign w_fall        = w_div_wrap & r_bclk;
    assign w_bit_next    = r_bit_idx + BIT_W'(1);
    assign w_frame_start = w_fall & (w_bit_next == '0);

    assign w_pop  = w_frame_start & ~w_empty;
    // A full FIFO still accepts a pair when the frame start frees a slot.
    assign w_push = sample_ce & (~w_full | w_pop);
    assign w_din  = {input_l, input_r};

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_din),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Bit index resets to 31 so the first falling event opens a frame.
    // Entering bit b the line carries frame_word[32-b]; for b = 0 that
    // index is 0 of the outgoing word, so both cases reduce to
    // frame_word[31 - old_idx] read before the word reloads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx    <= '1;
            r_lrck       <= 1'b1;
            r_sdata      <= 1'b0;
            r_frame_word <= '0;
        end else if (w_fall) begin
            r_bit_idx <= w_bit_next;
            r_lrck    <= w_bit_next[BIT_W-1];
            r_sdata   <= r_frame_word[~r_bit_idx];
            if (w_frame_start) begin
                if (!w_empty) begin
                    r_frame_word <= w_head;
                end else begin
`ifdef AUDIO_I2S_TX_ZERO_ON_UNDERRUN_EN
                    r_frame_word <= '0;
`else
                    r_frame_word <= r_frame_word;
`endif
                end
            end
        end
    end

    // New events take priority over clr_status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_frame_start && w_empty) begin
                r_underrun <= 1'b1;
            end else if (clr_status) begin
                r_underrun <= 1'b0;
            end
            if (sample_ce && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_status) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign i2s_bclk  = r_bclk;
    assign i2s_lrck  = r_lrck;
    assign i2s_sdata = r_sdata;
    assign underrun  = r_underrun;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;

    localparam int BCLK_DIV   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_CYC  = 64 * BCLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_ce = 1'b0;
    logic        clr_status = 1'b0;
    logic [15:0] input_l = '0;
    logic [15:0] input_r = '0;
    logic        i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_ce  (sample_ce),
        .input_l    (input_l),
        .input_r    (input_r),
        .clr_status (clr_status),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_sdata  (i2s_sdata),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    // Inputs as seen by the DUT at each active edge.
    logic        ce_s = 1'b0;
    logic        clr_s = 1'b0;
    logic [31:0] din_s = '0;
    always @(posedge clk) begin
        ce_s  = sample_ce & reset_n;
        clr_s = clr_status & reset_n;
        din_s = {input_l, input_r};
    end

    // Scoreboard: model FIFO, expected frame queue, expected flags.
    logic [31:0] mfifo[$];
    logic [31:0] exp_q[$];
    logic [31:0] mframe = '0;
    logic [31:0] rx_word = '0;
    logic [31:0] exp_w;
    logic        exp_under = 1'b0;
    logic        exp_over = 1'b0;
    logic        prev_bclk = 1'b0;
    logic        rx_valid = 1'b0;
    logic        m_fs;
    int          idx = 31;
    int          frames_checked = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            mfifo.delete();
            exp_q.delete();
            mframe    = '0;
            rx_word   = '0;
            exp_under = 1'b0;
            exp_over  = 1'b0;
            prev_bclk = 1'b0;
            rx_valid  = 1'b0;
            idx       = 31;
        end else begin
            m_fs = 1'b0;
            if (clr_s) begin
                exp_under = 1'b0;
                exp_over  = 1'b0;
            end
            if (prev_bclk && !i2s_bclk) begin
                idx  = (idx + 1) % 32;
                m_fs = (idx == 0);
            end
            if (m_fs) begin
                if (mfifo.size() > 0) begin
                    mframe = mfifo.pop_front();
                end else begin
`ifdef AUDIO_I2S_TX_ZERO_ON_UNDERRUN_EN
                    mframe = '0;
`endif
                    exp_under = 1'b1;
                end
                exp_q.push_back(mframe);
            end
            if (ce_s) begin
                if (mfifo.size() < FIFO_DEPTH) mfifo.push_back(din_s);
                else exp_over = 1'b1;
            end
            if (!prev_bclk && i2s_bclk) begin
                checks++;
                if (i2s_lrck !== (idx >= 16)) begin
                    errors++;
                    $display("FAIL lrck at bit %0d: got %b exp %b", idx, i2s_lrck, (idx >= 16));
                end
                if (idx == 0) begin
                    if (rx_valid) begin
                        rx_word[0] = i2s_sdata;
                        checks++;
                        if (exp_q.size() < 2) begin
                            errors++;
                            $display("FAIL frame_queue: got %0d entries exp >=2", exp_q.size());
                        end else begin
                            exp_w = exp_q.pop_front();
                            if (rx_word !== exp_w) begin
                                errors++;
                                $display("FAIL frame_data: got %h exp %h", rx_word, exp_w);
                            end
                            frames_checked++;
                        end
                    end else begin
                        checks++;
                        if (i2s_sdata !== 1'b0) begin
                            errors++;
                            $display("FAIL first_bit0: got %b exp 0", i2s_sdata);
                        end
                    end
                end else begin
                    rx_word[32-idx] = i2s_sdata;
                    if (idx == 1) rx_valid = 1'b1;
                end
            end
            checks += 2;
            if (underrun !== exp_under) begin
                errors++;
                $display("FAIL underrun_flag: got %b exp %b", underrun, exp_under);
            end
            if (overflow !== exp_over) begin
                errors++;
                $display("FAIL overflow_flag: got %b exp %b", overflow, exp_over);
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        sample_ce  = 1'b0;
        clr_status = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        input_l   = l;
        input_r   = r;
        sample_ce = 1'b1;
        @(posedge clk);
        #1 sample_ce = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int target;
        int cyc;
        target = frames_checked + n;
        cyc = 0;
        while (frames_checked < target && cyc < (n + 4) * FRAME_CYC) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (frames_checked < target) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames exp %0d", frames_checked, target);
        end
    endtask

    // Counts cycles after release to first bclk rise and fall.
    task automatic measure_start(output int rise_c, output int fall_c, output logic under15,
                                 output logic under16);
        rise_c = 0;
        fall_c = 0;
        under15 = 1'b0;
        under16 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (rise_c == 0 && i2s_bclk) rise_c = c;
            if (rise_c != 0 && fall_c == 0 && !i2s_bclk) fall_c = c;
            if (c == 15) under15 = underrun;
            if (c == 16) under16 = underrun;
        end
    endtask

    task automatic test_reset();
        int   rc, fc;
        logic u15, u16;
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp 01000",
                     {i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow});
        end
        reset_n = 1'b1;
        checks++;
        if (i2s_lrck !== 1'b1 || i2s_bclk !== 1'b0) begin
            errors++;
            $display("FAIL release_clocks: got lrck=%b bclk=%b exp 1 0", i2s_lrck, i2s_bclk);
        end
        measure_start(rc, fc, u15, u16);
        checks++;
        if (rc != BCLK_DIV) begin
            errors++;
            $display("FAIL first_rise: got %0d exp %0d", rc, BCLK_DIV);
        end
        checks++;
        if (fc != 2 * BCLK_DIV) begin
            errors++;
            $display("FAIL first_fall: got %0d exp %0d", fc, 2 * BCLK_DIV);
        end
        checks++;
        if (u15 !== 1'b0 || u16 !== 1'b1) begin
            errors++;
            $display("FAIL underrun_timing: got %b%b exp 01", u15, u16);
        end
        wait_frames(2);
    endtask

    task automatic test_single_frame();
        do_reset();
        push_pair(16'hA5C3, 16'h5A3C);
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (i2s_sdata !== 1'b0) begin
            errors++;
            $display("FAIL bit0_prev_frame: got %b exp 0", i2s_sdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (i2s_sdata !== 1'b1 || i2s_lrck !== 1'b0) begin
            errors++;
            $display("FAIL left_msb: got sdata=%b lrck=%b exp 1 0", i2s_sdata, i2s_lrck);
        end
        wait_frames(2);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_early: got %b exp 0", overflow);
                end
            end
            push_pair(16'(16'h1000 + i), 16'(16'h2000 + i));
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b exp 1", overflow);
        end
        wait_frames(5);
    endtask

    task automatic test_underrun();
        do_reset();
        push_pair(16'h1234, 16'h8001);
        repeat (526) @(posedge clk);
        #1 clr_status = 1'b1;
        @(posedge clk);
        #1 clr_status = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL clr_set_wins: got %b exp 1", underrun);
        end
        clr_status = 1'b1;
        @(posedge clk);
        #1 clr_status = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL clr_status: got %b exp 0", underrun);
        end
        wait_frames(2);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_again: got %b exp 1", underrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push_pair(16'(16'h3000 + i), 16'(16'hC000 + i));
        end
        repeat (11) @(posedge clk);
        #1;
        push_pair(16'h3005, 16'hC005);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_overflow: got %b exp 0", overflow);
        end
        wait_frames(6);
    endtask

    task automatic test_midframe_reset();
        int   rc, fc, cyc;
        logic u15, u16;
        do_reset();
        push_pair(16'hFFFF, 16'h0F0F);
        push_pair(16'h7777, 16'h6666);
        cyc = 0;
        while (!(idx == 10 && i2s_bclk) && cyc < 2 * FRAME_CYC) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(idx == 10 && i2s_bclk)) begin
            errors++;
            $display("FAIL midframe_wait: got idx %0d exp 10", idx);
        end
        checks++;
        if (i2s_sdata !== 1'b1 || i2s_lrck !== 1'b0) begin
            errors++;
            $display("FAIL midframe_state: got sdata=%b lrck=%b exp 1 0", i2s_sdata, i2s_lrck);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow} !== 5'b01000) begin
            errors++;
            $display("FAIL async_reset: got %b exp 01000",
                     {i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow});
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        measure_start(rc, fc, u15, u16);
        checks++;
        if (fc != 2 * BCLK_DIV || u16 !== 1'b1) begin
            errors++;
            $display("FAIL restart: got fall %0d underrun %b exp %0d 1", fc, u16, 2 * BCLK_DIV);
        end
        wait_frames(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_underrun();
        test_back_to_back();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stereo I2S serializer that sits directly downstream of the audio IIR filter. It captures the filter's signed 16-bit left/right pair on each `sample_ce` into a small FIFO, then shifts it out MSB-first in a standard I2S frame. All outputs are registered, and the block generates its own bit and word clocks from `clk`. Underrun and overflow are flagged with sticky status bits.

## Interface
- `BCLK_DIV`, default 8: `clk` cycles per half bit-clock period; must be ≥2.
- `FIFO_DEPTH`, default 4: sample-pair entries; power of two, ≥2.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_ce` in 1: one-cycle strobe; capture `input_l`/`input_r` this cycle.
- `input_l` in 16: signed left sample.
- `input_r` in 16: signed right sample.
- `clr_status` in 1: synchronous clear of the sticky flags.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrck` out 1: word select; 0 = left, 1 = right.
- `i2s_sdata` out 1: serial data.
- `underrun` out 1: sticky; a frame started with the FIFO empty.
- `overflow` out 1: sticky; `sample_ce` arrived with the FIFO full.

## Operation
- **FIFO write:** `sample_ce` with the FIFO not full pushes `{input_l, input_r}`.
  - `sample_ce` with the FIFO full drops the new pair, keeps the FIFO contents, and sets `overflow`.
- **Clock divider:** `div_cnt` counts 0..BCLK_DIV-1. At BCLK_DIV-1 it wraps to 0 and `i2s_bclk` toggles.
  - A toggle 1→0 is a falling event. Every state update below happens only on falling events.
- **Bit index:** `bit_idx` is 0..31 and increments on each falling event, wrapping 31→0.
  - `i2s_lrck` = 0 while `bit_idx` is 0..15 and 1 while it is 16..31. It is registered and updated on the same falling event.
- **Frame start:** the falling event that enters `bit_idx` = 0.
  - FIFO not empty: pop the head into `frame_word[31:0]` = {L, R}.
  - FIFO empty: `frame_word` keeps its previous value (the last pair repeats) and `underrun` is set.
- **I2S one-bit delay:**
  - At `bit_idx` = 0, `i2s_sdata` = `frame_word[0]` of the previous frame.
  - At `bit_idx` = b for b = 1..31, `i2s_sdata` = `frame_word[32-b]` of the current frame.
  - Consequence: the left MSB appears at b = 1 and the right MSB at b = 17.
- **Simultaneous push and pop** in one cycle: both happen and the occupancy is unchanged.
  - If the FIFO was full, the push is still accepted because the pop frees the entry.
- **Status clear:** `clr_status` in the same cycle as a new underrun or overflow event leaves the flag set (set wins).
- **Reset (asserted at any time, including mid-frame):**
  - Outputs: `i2s_bclk` = 0, `i2s_lrck` = 1, `i2s_sdata` = 0, flags = 0.
  - Internal state: FIFO empty, `frame_word` = 0, `div_cnt` = 0, `bit_idx` = 31.
  - The first falling event after release therefore starts a frame.

## Timing
- Bit-clock period is 2·BCLK_DIV `clk` cycles; the frame is 64·BCLK_DIV cycles.
- With `clk` = 24.576 MHz and BCLK_DIV = 8, the frame rate is 48 kHz.
- `i2s_bclk`, `i2s_lrck` and `i2s_sdata` change in the same `clk` cycle, on the `i2s_bclk` falling edge. Data is stable across the rising edge.
- After `reset_n` deasserts, the first `i2s_bclk` rise comes after BCLK_DIV cycles and the first fall after 2·BCLK_DIV cycles.
- A pair pushed at least one cycle before a frame-start falling event is sent in that frame. At frame start its left MSB appears at `bit_idx` = 1, i.e. 2·BCLK_DIV cycles later.
- Flags assert one cycle after the causing event.

## Configuration
- **`AUDIO_I2S_TX_ZERO_ON_UNDERRUN_EN` defined:** on underrun, `frame_word` loads 0, so the frame sends silence.
- **Not defined:** the last pair repeats.
- `underrun` is set in both builds.

## Structure
- **`audio_pkg`** holds:
  - `typedef logic signed [15:0] sample_t`
  - `typedef struct packed {sample_t l; sample_t r;} stereo_t`
  - `localparam FRAME_BITS = 32`
- **`audio_sample_fifo`** is the one sub-module: a synchronous FIFO of `stereo_t`, parameterised by depth.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Same clock and reset as the top.
  - First-word fall-through.
- The top holds the divider, bit counter, shift logic and flags.

## Test plan
- **Reset:** hold `reset_n` = 0 for 5 cycles, release, with no samples pushed → `i2s_lrck` = 1 and `i2s_bclk` = 0 at release; first `bclk` fall at cycle 16 (BCLK_DIV = 8); `underrun` = 1 one cycle after the first frame start; `sdata` all 0.
- **Single frame:** push L = 16'hA5C3, R = 16'h5A3C before the first frame start → sampled on `bclk` rising edges, bits 1..16 = A5C3 MSB-first and bits 17..31 plus the next frame's bit 0 = 5A3C.
- **Overflow:** push 5 pairs back-to-back with FIFO_DEPTH = 4 and no frame start in between → `overflow` = 1; the 4 frames that follow carry pairs 1–4 only.
- **Underrun repeat vs zero:** push one pair 16'h1234/16'h8001, then no more → frame 2 repeats 1234/8001 (macro undefined) or sends 0/0 (macro defined); `underrun` = 1.
- **Simultaneous push/pop:** fill the FIFO to 4 and assert `sample_ce` in the frame-start cycle → push accepted, occupancy stays 4, `overflow` = 0.
- **Mid-frame reset:** assert `reset_n` = 0 at `bit_idx` = 10 → outputs go to reset values asynchronously and the FIFO is empty; after release a clean frame starts 2·BCLK_DIV cycles later.
